// File: rtl/adder_bist.sv
// adder_bist: LFSR-driven built-in self test for an external 16-bit adder.
// Ports: CLK, reset (sync, active-low), start;
//        in_a/in_b/cin drive the adder under test, s/cout are sampled back;
//        busy, done, pass, pass_count, fail_count report the run;
//        first_fail_a/b/cin/s capture the first mismatching vector.
// Build option: define ADDER_BIST_COUT_CHECK_EN to include cout in the comparison.
module adder_bist #(
    parameter int unsigned NUM_TESTS     = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [31:0] SEED          = 32'hACE1_2019
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] in_a,
    output logic [15:0] in_b,
    output logic        cin,
    input  logic [15:0] s,
    input  logic        cout,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  pass_count,
    output logic [7:0]  fail_count,
    output logic [15:0] first_fail_a,
    output logic [15:0] first_fail_b,
    output logic        first_fail_cin,
    output logic [15:0] first_fail_s
);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [31:0] SEED_INIT   = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] MASK        = 32'h8020_0003;
    localparam logic [7:0]  LAST        = 8'(NUM_TESTS - 1);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, DONE} state_t;
    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [16:0] expected;
    logic [7:0]  index;
    logic [3:0]  settle_cnt;
    logic        match;
    always_comb lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
`ifdef ADDER_BIST_COUT_CHECK_EN
    assign match = ({cout, s} == expected);
`else
    logic unused_cout;
    assign unused_cout = cout;
    assign match = (s == expected[15:0]);
`endif
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state          <= IDLE;
            lfsr           <= SEED_INIT;
            in_a           <= '0;
            in_b           <= '0;
            cin            <= 1'b0;
            expected       <= '0;
            index          <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_cin <= 1'b0;
            first_fail_s   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state          <= LOAD;
                    busy           <= 1'b1;
                    done           <= 1'b0;
                    pass           <= 1'b0;
                    index          <= '0;
                    pass_count     <= '0;
                    fail_count     <= '0;
                    first_fail_a   <= '0;
                    first_fail_b   <= '0;
                    first_fail_cin <= 1'b0;
                    first_fail_s   <= '0;
                end
                LOAD: begin
                    lfsr       <= lfsr_next;
                    in_a       <= lfsr_next[15:0];
                    in_b       <= {1'b0, lfsr_next[30:16]};
                    cin        <= lfsr_next[31];
                    expected   <= {1'b0, lfsr_next[15:0]} + {2'b0, lfsr_next[30:16]} + {16'b0, lfsr_next[31]};
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) state <= CHECK;
                    else settle_cnt <= settle_cnt + 4'd1;
                end
                CHECK: begin
                    if (match) begin
                        pass_count <= pass_count + {7'b0, pass_count != 8'hFF};
                    end else begin
                        fail_count <= fail_count + {7'b0, fail_count != 8'hFF};
                        // A zero tally means this is the first mismatch of the run.
                        if (fail_count == 8'd0) begin
                            first_fail_a   <= in_a;
                            first_fail_b   <= in_b;
                            first_fail_cin <= cin;
                            first_fail_s   <= s;
                        end
                    end
                    if (index == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= match && (fail_count == 8'd0);
                    end else begin
                        index <= index + 8'd1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed self-checking bench for adder_bist with a behavioural adder model.
// Ports: none; drives CLK/reset/start and models the adder under test through mode.
module tb_adder_bist;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in_a, in_b, s, first_fail_a, first_fail_b, first_fail_s;
    logic        cin, cout, busy, done, pass, first_fail_cin;
    logic [7:0]  pass_count, fail_count;
    logic [16:0] ideal;
    int          mode = 0;
    int          compared = 0;
    int          mismatched = 0;
    // Vector 1 from the default seed, worked by hand:
    // step(ACE12019) = 5670900C ^ 80200003 = D650900F -> a=900F b=5650 cin=1, sum=E660
    localparam logic [15:0] V1_A = 16'h900F;
    localparam logic [15:0] V1_B = 16'h5650;
    localparam logic        V1_C = 1'b1;
    localparam logic [15:0] V1_S = 16'hE660;

    adder_bist dut (
        .CLK(CLK), .reset(reset), .start(start),
        .in_a(in_a), .in_b(in_b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_a(first_fail_a), .first_fail_b(first_fail_b),
        .first_fail_cin(first_fail_cin), .first_fail_s(first_fail_s)
    );

    always #5 CLK = ~CLK;

    // mode 0: ideal adder, 1: sum bit 0 flipped, 2: carry-out inverted
    assign ideal = {1'b0, in_a} + {1'b0, in_b} + {16'b0, cin};
    assign s     = ideal[15:0] ^ ((mode == 1) ? 16'h0001 : 16'h0000);
    assign cout  = ideal[16] ^ (mode == 2);

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Waits for done, counting edges after the acceptance edge; bounded.
    task automatic wait_done(input string name, input int want, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 400);
        compared++;
        if (n !== want) begin
            $display("FAIL %s_latency: got %0d edges, want %0d", name, n, want);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        compared++;
        if ({in_a, in_b, cin} !== 33'd0) begin
            $display("FAIL reset_operands: got %h/%h/%b want 0", in_a, in_b, cin);
            mismatched++;
        end
        compared++;
        if ({busy, done, pass} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
            mismatched++;
        end
        compared++;
        if ({pass_count, fail_count} !== 16'd0) begin
            $display("FAIL reset_counts: got %0d/%0d want 0/0", pass_count, fail_count);
            mismatched++;
        end
        compared++;
        if ({first_fail_a, first_fail_b, first_fail_cin, first_fail_s} !== 49'd0) begin
            $display("FAIL reset_first_fail: got %h %h %b %h want 0", first_fail_a, first_fail_b, first_fail_cin, first_fail_s);
            mismatched++;
        end
    endtask

    task automatic test_ideal();
        int n;
        logic [32:0] v1, v1_late;
        do_reset();
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        v1 = '0;
        v1_late = '0;
        do begin
            tick();
            n++;
            if (n == 1) v1 = {in_a, in_b, cin};
            if (n == 5) v1_late = {in_a, in_b, cin};
        end while (!done && n < 400);
        compared++;
        if (n !== 96) begin
            $display("FAIL ideal_latency: got %0d edges, want 96", n);
            mismatched++;
        end
        compared++;
        if (v1 !== {V1_A, V1_B, V1_C}) begin
            $display("FAIL ideal_vector1: got %h want %h", v1, {V1_A, V1_B, V1_C});
            mismatched++;
        end
        compared++;
        if (v1_late !== v1) begin
            $display("FAIL settle_hold: got %h want %h", v1_late, v1);
            mismatched++;
        end
        compared++;
        if ({pass_count, fail_count, pass, busy} !== {8'd16, 8'd0, 1'b1, 1'b0}) begin
            $display("FAIL ideal_result: got pc=%0d fc=%0d pass=%b busy=%b want 16/0/1/0", pass_count, fail_count, pass, busy);
            mismatched++;
        end
        tick();
        tick();
        tick();
        compared++;
        if ({done, pass} !== 2'b11) begin
            $display("FAIL done_held: got %b want 11", {done, pass});
            mismatched++;
        end
    endtask

    task automatic test_sum_fault();
        int n;
        do_reset();
        mode  = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("sum_fault", 96, n);
        compared++;
        if ({pass_count, fail_count, pass} !== {8'd0, 8'd16, 1'b0}) begin
            $display("FAIL sum_fault_result: got pc=%0d fc=%0d pass=%b want 0/16/0", pass_count, fail_count, pass);
            mismatched++;
        end
        compared++;
        if ({first_fail_a, first_fail_b, first_fail_cin, first_fail_s} !== {V1_A, V1_B, V1_C, V1_S ^ 16'h0001}) begin
            $display("FAIL first_fail: got %h %h %b %h want %h %h %b %h", first_fail_a, first_fail_b, first_fail_cin, first_fail_s, V1_A, V1_B, V1_C, V1_S ^ 16'h0001);
            mismatched++;
        end
        mode = 0;
    endtask

    task automatic test_midrun_reset();
        do_reset();
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (26) tick();
        compared++;
        if (pass_count !== 8'd4) begin
            $display("FAIL midrun_pre: got pc=%0d want 4", pass_count);
            mismatched++;
        end
        // Edge 27 falls inside the SETTLE phase of vector 5.
        reset = 1'b0;
        start = 1'b1;
        tick();
        reset = 1'b1;
        start = 1'b0;
        compared++;
        if ({busy, done, pass_count, in_a, in_b, cin} !== 43'd0) begin
            $display("FAIL midrun_reset: got busy=%b done=%b pc=%0d a=%h b=%h c=%b want all 0", busy, done, pass_count, in_a, in_b, cin);
            mismatched++;
        end
        tick();
        compared++;
        if (busy !== 1'b0) begin
            $display("FAIL midrun_idle: got busy=%b want 0", busy);
            mismatched++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        compared++;
        if ({in_a, in_b, cin} !== {V1_A, V1_B, V1_C}) begin
            $display("FAIL midrun_restart_vector: got %h/%h/%b want %h/%h/%b", in_a, in_b, cin, V1_A, V1_B, V1_C);
            mismatched++;
        end
    endtask

    task automatic test_cout_fault();
        int n;
        do_reset();
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("cout_fault", 96, n);
`ifdef ADDER_BIST_COUT_CHECK_EN
        compared++;
        if ({pass_count, fail_count, pass} !== {8'd0, 8'd16, 1'b0}) begin
            $display("FAIL cout_checked: got pc=%0d fc=%0d pass=%b want 0/16/0", pass_count, fail_count, pass);
            mismatched++;
        end
`else
        compared++;
        if ({pass_count, fail_count, pass} !== {8'd16, 8'd0, 1'b1}) begin
            $display("FAIL cout_ignored: got pc=%0d fc=%0d pass=%b want 16/0/1", pass_count, fail_count, pass);
            mismatched++;
        end
`endif
        mode = 0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] v;
        v = 32'hACE1_2019;
        for (int i = 0; i < 17; i++) v = lfsr_step(v);
        do_reset();
        mode  = 0;
        start = 1'b1;
        tick();
        wait_done("held_start", 96, n);
        tick();
        compared++;
        if ({busy, done, pass_count} !== {1'b1, 1'b0, 8'd0}) begin
            $display("FAIL restart_state: got busy=%b done=%b pc=%0d want 1/0/0", busy, done, pass_count);
            mismatched++;
        end
        tick();
        start = 1'b0;
        compared++;
        if ({in_a, in_b, cin} !== {v[15:0], 1'b0, v[30:16], v[31]}) begin
            $display("FAIL restart_vector: got %h/%h/%b want %h/%h/%b", in_a, in_b, cin, v[15:0], {1'b0, v[30:16]}, v[31]);
            mismatched++;
        end
        wait_done("second_run", 95, n);
        compared++;
        if ({pass_count, pass} !== {8'd16, 1'b1}) begin
            $display("FAIL second_run_result: got pc=%0d pass=%b want 16/1", pass_count, pass);
            mismatched++;
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_sum_fault();
        test_midrun_reset();
        test_cout_fault();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter NUM_TESTS, default 16, number of vectors per run (1..255).
REQ-002 Parameter SETTLE_CYCLES, default 4, cycles operands are held before the result is checked (1..15).
REQ-003 Parameter SEED, default 32'hACE1_2019, initial LFSR state; value 0 SHALL be replaced by 32'h1.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  run request, sampled in IDLE and DONE only.
REQ-007 in_a  output  16  operand A to adder under test.
REQ-008 in_b  output  16  operand B to adder under test.
REQ-009 cin  output  1  carry-in to adder under test.
REQ-010 s  input  16  sum from adder under test.
REQ-011 cout  input  1  carry-out from adder under test.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete; held until restart or reset.
REQ-014 pass  output  1  done and fail_count == 0.
REQ-015 pass_count, fail_count  output  8 each  per-run result tallies.
REQ-016 first_fail_a, first_fail_b  output  16 each; first_fail_cin  output  1; first_fail_s  output  16: operands and DUT sum of the first failing vector.

Function
REQ-017 FSM states IDLE, LOAD, SETTLE, CHECK, DONE; one transition per CLK edge.
REQ-018 IDLE: start=1 -> LOAD, clearing pass_count, fail_count, first_fail_* and test index; else stay.
REQ-019 LOAD: LFSR advances one step (Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h80200003); in_a <= next[15:0], in_b <= {1'b0,next[30:16]}, cin <= next[31]; expected <= 17-bit in_a+in_b+cin of the new values; -> SETTLE.
REQ-020 SETTLE: operands held constant; stays exactly SETTLE_CYCLES cycles, then -> CHECK.
REQ-021 CHECK: match when s == expected[15:0]; match increments pass_count, else fail_count; first mismatch of the run loads first_fail_*; later mismatches do not overwrite.
REQ-022 CHECK: if test index == NUM_TESTS-1 -> DONE, else index++ and -> LOAD.
REQ-023 Each vector occupies 2+SETTLE_CYCLES cycles; DONE entered exactly NUM_TESTS*(2+SETTLE_CYCLES) edges after start is accepted.
REQ-024 busy = 1 in LOAD, SETTLE, CHECK; done = 1 in DONE only.
REQ-025 start while busy SHALL be ignored; start=1 in DONE restarts as from IDLE, LFSR continuing from its current state.
REQ-026 Counters saturate at 255; no wrap.
REQ-027 in_a, in_b, cin SHALL change only on the LOAD edge.

Reset
REQ-028 reset=0 at a CLK edge, in any state including mid-run: state IDLE, LFSR=SEED, in_a=in_b=0, cin=0, all counters, first_fail_*, busy, done, pass = 0.
REQ-029 reset has priority over start on the same edge.

Configuration
REQ-030 Macro ADDER_BIST_COUT_CHECK_EN defined: match requires {cout,s} == expected[16:0]; undefined: cout ignored, match uses s only (port still present).

Verification
REQ-031 reset=0 for 2 edges, then 1 -> all outputs 0, state IDLE, busy=0.
REQ-032 Ideal adder model, defaults, start pulse -> done rises 96 edges after acceptance, pass_count=16, fail_count=0, pass=1.
REQ-033 Model returning correct sum ^ 16'h0001 -> fail_count=16, pass=0, first_fail_* equal vector 1 operands and its corrupted sum.
REQ-034 reset=0 during SETTLE of vector 5 -> IDLE next edge, counters 0; restart reproduces vector 1 operands identically.
REQ-035 Model with cout inverted, sum correct -> with ADDER_BIST_COUT_CHECK_EN fail_count=16; without, pass_count=16.
REQ-036 start held high throughout run -> single run of 16 vectors, then immediate restart from DONE with fresh LFSR vectors.
